riscv_inst_encoder: RTL

- Assembles 32-bit RV64 instruction words from field-level requests; the inverse of the decode-side instruction unions and opcode enums.
- Expands the LI32 pseudo-op into a one- or two-instruction sequence.
- Used by the debug program-buffer filler and the self-test instruction injector.
- Streams words out over a valid/ready port toward fetch or the program buffer.

---
 rtl/riscv_pkg.sv | 101 ++++++++++
 rtl/riscv_inst_pack.sv | 77 +++++++
 rtl/riscv_inst_encoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: instruction field unions, encoder format/state enums and constants
// shared by the instruction encoder and its packer.
`default_nettype none

package riscv_pkg;

  localparam int INST_SIZE = 32;
  localparam int NUM_FMT   = 7;

  localparam logic [6:0] OP_LUI        = 7'b0110111;
  localparam logic [6:0] OP_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_OP_IMM_32  = 7'b0011011;

  localparam logic [31:0]        LI_ROUND  = 32'h0000_0800;
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;

  typedef enum logic [$clog2(NUM_FMT)-1:0] {
    ENC_R    = 3'd0,
    ENC_I    = 3'd1,
    ENC_S    = 3'd2,
    ENC_B    = 3'd3,
    ENC_U    = 3'd4,
    ENC_J    = 3'd5,
    ENC_LI32 = 3'd6
  } enc_fmt_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    LI_LO = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } itype_t;

  typedef struct packed {
    logic [6:0] imm5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] imm0;
    logic [6:0] opcode;
  } stype_t;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [3:0] imm1;
    logic       imm11;
    logic [6:0] opcode;
  } btype_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } utype_t;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm1;
    logic       imm11;
    logic [7:0] imm12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } jtype_t;

  typedef union packed {
    rtype_t rtype;
    itype_t itype;
    stype_t stype;
    btype_t btype;
    utype_t utype;
    jtype_t jtype;
  } instruction_t;

  // True when all bits selected by mask equal the sign, i.e. v fits the narrower signed field.
  function automatic logic sext_ok(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == 32'd0) || ((v & mask) == mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_inst_pack.sv
// riscv_inst_pack: combinational packer from format plus fields to one 32-bit instruction word.
`default_nettype none

module riscv_inst_pack
  import riscv_pkg::*;
(
  input  enc_fmt_t               fmt,
  input  logic [6:0]             opcode,
  input  logic [2:0]             func3,
  input  logic [6:0]             func7,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [31:0]            imm,
  output logic [INST_SIZE-1:0]   inst
);

  instruction_t word;

  always_comb begin
    word = '0;
    case (fmt)
      ENC_R: begin
        word.rtype.func7  = func7;
        word.rtype.rs2    = rs2;
        word.rtype.rs1    = rs1;
        word.rtype.func3  = func3;
        word.rtype.rd     = rd;
        word.rtype.opcode = opcode;
      end
      ENC_I: begin
        word.itype.imm    = imm[11:0];
        word.itype.rs1    = rs1;
        word.itype.func3  = func3;
        word.itype.rd     = rd;
        word.itype.opcode = opcode;
      end
      ENC_S: begin
        word.stype.imm5   = imm[11:5];
        word.stype.rs2    = rs2;
        word.stype.rs1    = rs1;
        word.stype.func3  = func3;
        word.stype.imm0   = imm[4:0];
        word.stype.opcode = opcode;
      end
      ENC_B: begin
        word.btype.imm12  = imm[12];
        word.btype.imm5   = imm[10:5];
        word.btype.rs2    = rs2;
        word.btype.rs1    = rs1;
        word.btype.func3  = func3;
        word.btype.imm1   = imm[4:1];
        word.btype.imm11  = imm[11];
        word.btype.opcode = opcode;
      end
      ENC_U: begin
        word.utype.imm    = imm[31:12];
        word.utype.rd     = rd;
        word.utype.opcode = opcode;
      end
      ENC_J: begin
        word.jtype.imm20  = imm[20];
        word.jtype.imm1   = imm[10:1];
        word.jtype.imm11  = imm[11];
        word.jtype.imm12  = imm[19:12];
        word.jtype.rd     = rd;
        word.jtype.opcode = opcode;
      end
      default: word = '0;
    endcase
  end

  assign inst = word;

endmodule

`default_nettype wire

// File: rtl/riscv_inst_encoder.sv
// riscv_inst_encoder: streams RV64 instruction words from field requests, expanding LI32.
// Optional field legality checking with err_o pulse when RISCV_ENC_CHECK_EN is defined.
`default_nettype none

module riscv_inst_encoder
  import riscv_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_fmt_i,
  input  logic [6:0]           req_opcode_i,
  input  logic [2:0]           req_func3_i,
  input  logic [6:0]           req_func7_i,
  input  logic [4:0]           req_rd_i,
  input  logic [4:0]           req_rs1_i,
  input  logic [4:0]           req_rs2_i,
  input  logic [31:0]          req_imm_i,
  input  logic                 kill_i,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  output logic [INST_SIZE-1:0] inst_o,
  output logic                 inst_last_o,
  output logic                 err_o
);

  enc_state_t             state, state_n;
  logic                   valid, valid_n;
  logic [INST_SIZE-1:0]   inst, inst_n;
  logic                   last, last_n;
  logic                   err, err_n;
  logic [4:0]             li_rd, li_rd_n;
  logic [11:0]            li_lo, li_lo_n;

  enc_fmt_t               fmt;
  logic                   fits12;
  logic [31:0]            li_sum;
  logic                   two_word;
  logic                   illegal;
  logic                   accept;

  enc_fmt_t               p_fmt;
  logic [6:0]             p_opcode;
  logic [2:0]             p_func3;
  logic [6:0]             p_func7;
  logic [4:0]             p_rd;
  logic [4:0]             p_rs1;
  logic [4:0]             p_rs2;
  logic [31:0]            p_imm;
  logic [INST_SIZE-1:0]   packed_word;

  assign fmt    = enc_fmt_t'(req_fmt_i);
  assign fits12 = ($signed(req_imm_i) >= IMM12_MIN) && ($signed(req_imm_i) <= IMM12_MAX);
  assign li_sum = req_imm_i + LI_ROUND;

  assign req_ready_o = (state == IDLE) && (!valid || inst_ready_i);
  assign accept      = req_valid_i && req_ready_o && !kill_i;

`ifdef RISCV_ENC_CHECK_EN
  always_comb begin
    illegal = 1'b0;
    case (fmt)
      ENC_I, ENC_S: illegal = !fits12;
      ENC_B:        illegal = req_imm_i[0] || !sext_ok(req_imm_i, 32'hFFFF_F000);
      ENC_J:        illegal = req_imm_i[0] || !sext_ok(req_imm_i, 32'hFFF0_0000);
      ENC_U:        illegal = (req_imm_i[11:0] != 12'd0);
      default:      illegal = 1'b0;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  // The single packer is shared: LI_LO feeds it ADDIW, otherwise the (possibly LI32-rewritten) request.
  always_comb begin
    p_fmt    = fmt;
    p_opcode = req_opcode_i;
    p_func3  = req_func3_i;
    p_func7  = req_func7_i;
    p_rd     = req_rd_i;
    p_rs1    = req_rs1_i;
    p_rs2    = req_rs2_i;
    p_imm    = req_imm_i;
    two_word = 1'b0;
    if (state == LI_LO) begin
      p_fmt    = ENC_I;
      p_opcode = OP_OP_IMM_32;
      p_func3  = 3'd0;
      p_rd     = li_rd;
      p_rs1    = li_rd;
      p_imm    = {{20{li_lo[11]}}, li_lo};
    end else if (fmt == ENC_LI32) begin
      p_func3 = 3'd0;
      if (fits12 || (req_rd_i == 5'd0)) begin
        p_fmt    = ENC_I;
        p_opcode = OP_OP_IMM;
        p_rs1    = 5'd0;
      end else begin
        p_fmt    = ENC_U;
        p_opcode = OP_LUI;
        p_imm    = {li_sum[31:12], 12'd0};
        two_word = (req_imm_i[11:0] != 12'd0);
      end
    end
  end

  riscv_inst_pack u_pack (
    .fmt    (p_fmt),
    .opcode (p_opcode),
    .func3  (p_func3),
    .func7  (p_func7),
    .rd     (p_rd),
    .rs1    (p_rs1),
    .rs2    (p_rs2),
    .imm    (p_imm),
    .inst   (packed_word)
  );

  always_comb begin
    state_n = state;
    valid_n = valid;
    inst_n  = inst;
    last_n  = last;
    err_n   = 1'b0;
    li_rd_n = li_rd;
    li_lo_n = li_lo;
    if (kill_i) begin
      valid_n = 1'b0;
      state_n = IDLE;
    end else if (accept) begin
      if (illegal) begin
        valid_n = 1'b0;
        err_n   = 1'b1;
      end else begin
        valid_n = 1'b1;
        inst_n  = packed_word;
        last_n  = !two_word;
        state_n = two_word ? LI_LO : IDLE;
        li_rd_n = req_rd_i;
        li_lo_n = req_imm_i[11:0];
      end
    end else if (valid && inst_ready_i) begin
      if ((state == LI_LO) && !last) begin
        valid_n = 1'b1;
        inst_n  = packed_word;
        last_n  = 1'b1;
      end else begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      valid <= 1'b0;
      inst  <= '0;
      last  <= 1'b0;
      err   <= 1'b0;
      li_rd <= 5'd0;
      li_lo <= 12'd0;
    end else begin
      state <= state_n;
      valid <= valid_n;
      inst  <= inst_n;
      last  <= last_n;
      err   <= err_n;
      li_rd <= li_rd_n;
      li_lo <= li_lo_n;
    end
  end

  assign inst_valid_o = valid;
  assign inst_o       = inst;
  assign inst_last_o  = last;
  assign err_o        = err;

endmodule

`default_nettype wire
